// File: rtl/gamepad_button_events.sv
// gamepad_button_events
//   Turns the 12 raw button levels from the gamepad Pmod decoder into
//   frame-synchronous debounced levels and one-cycle event pulses. Game logic
//   steps on these events rather than on raw levels.
//
//   All state changes happen only on clock edges where frame_tick is high.
//   Each button has its own debounce candidate flag and its own IDLE/DELAY/REPEAT
//   auto-repeat FSM with a frame counter.
//
// Ports
//   clk            in   system/pixel clock
//   rst_n          in   asynchronous active-low reset
//   btn_raw        in   [N_BTN] decoder button levels, 1 = pressed
//   is_present     in   controller detected; 0 forces every button released
//   frame_tick     in   one-cycle pulse per frame (any strobe is acceptable)
//   held           out  [N_BTN] debounced button level
//   press          out  [N_BTN] one-cycle pulse on a committed press
//   release_pulse  out  [N_BTN] one-cycle pulse on a committed release
//                       ("release" itself is a reserved word)
//   evt            out  [N_BTN] one-cycle pulse on press and on every auto-repeat
module gamepad_button_events #(
  parameter int N_BTN         = 12,
  parameter int DELAY_FRAMES  = 20,
  parameter int REPEAT_FRAMES = 4,
  parameter int CNT_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             is_present,
  input  logic             frame_tick,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] evt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Compare values are one bit wider than the counter so that cnt+1 never
  // overflows before the compare.
  localparam logic [CNT_W:0] DLY_CMP = (CNT_W+1)'(DELAY_FRAMES);
  localparam logic [CNT_W:0] REP_CMP = (CNT_W+1)'(REPEAT_FRAMES);

  state_t           state_r [N_BTN];
  state_t           state_s [N_BTN];
  logic [CNT_W-1:0] cnt_r   [N_BTN];
  logic [CNT_W-1:0] cnt_s   [N_BTN];
  logic [CNT_W:0]   inc_s;

  logic [N_BTN-1:0] cand_r, cand_s;
  logic [N_BTN-1:0] held_r, held_s;
  logic [N_BTN-1:0] press_r, press_s;
  logic [N_BTN-1:0] release_r, release_s;
  logic [N_BTN-1:0] evt_r, evt_s;

  assign held          = held_r;
  assign press         = press_r;
  assign release_pulse = release_r;
  assign evt           = evt_r;

  // Next-state and pulse logic for every button's debounce and repeat FSM.
  always_comb begin
    inc_s     = '0;
    cand_s    = cand_r;
    held_s    = held_r;
    press_s   = '0;
    release_s = '0;
    evt_s     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
    end

    for (int i = 0; i < N_BTN; i++) begin
      inc_s = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};
      if (frame_tick) begin
        if (!is_present) begin
          // Unplug: drop everything, report release for whatever was held.
          release_s[i] = held_r[i];
          held_s[i]    = 1'b0;
          cand_s[i]    = 1'b0;
          state_s[i]   = ST_IDLE;
          cnt_s[i]     = '0;
        end else if ((btn_raw[i] != held_r[i]) && cand_r[i]) begin
          // Second consecutive disagreeing sample: commit the new level.
          // A release commit overrides any repeat expiry on the same tick.
          held_s[i] = btn_raw[i];
          cand_s[i] = 1'b0;
          cnt_s[i]  = '0;
          if (btn_raw[i]) begin
            press_s[i] = 1'b1;
            evt_s[i]   = 1'b1;
            state_s[i] = ST_DELAY;
          end else begin
            release_s[i] = 1'b1;
            state_s[i]   = ST_IDLE;
          end
        end else begin
          // A pending release candidate does not pause repeat counting.
          cand_s[i] = (btn_raw[i] != held_r[i]);
          case (state_r[i])
            ST_IDLE: begin
              cnt_s[i] = '0;
            end
            ST_DELAY: begin
              if (inc_s == DLY_CMP) begin
                evt_s[i]   = 1'b1;
                cnt_s[i]   = '0;
                state_s[i] = ST_REPEAT;
              end else begin
                cnt_s[i] = inc_s[CNT_W-1:0];
              end
            end
            ST_REPEAT: begin
              if (inc_s == REP_CMP) begin
                evt_s[i] = 1'b1;
                cnt_s[i] = '0;
              end else begin
                cnt_s[i] = inc_s[CNT_W-1:0];
              end
            end
            default: begin
              state_s[i] = ST_IDLE;
              cnt_s[i]   = '0;
            end
          endcase
        end
      end else begin
        // No frame tick: state holds, pulses stay low.
        cand_s[i] = cand_r[i];
      end
    end
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r    <= '0;
      held_r    <= '0;
      press_r   <= '0;
      release_r <= '0;
      evt_r     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      cand_r    <= cand_s;
      held_r    <= held_s;
      press_r   <= press_s;
      release_r <= release_s;
      evt_r     <= evt_s;
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_gamepad_button_events.sv
module tb_gamepad_button_events;

  localparam int NB = 12;
  localparam int D  = 3;
  localparam int R  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          is_present = 1'b1;
  logic          frame_tick = 1'b0;
  logic [NB-1:0] held, press, release_pulse, evt;

  int errors = 0;
  int checks = 0;

  // Reference model: event schedule computed from the commit tick number.
  int            tick_no = 0;
  int            press_tick [NB];
  logic [NB-1:0] m_held = '0;
  logic [NB-1:0] m_cand = '0;
  logic [NB-1:0] e_press = '0, e_rel = '0, e_evt = '0;

  gamepad_button_events #(
    .N_BTN(NB), .DELAY_FRAMES(D), .REPEAT_FRAMES(R), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .is_present(is_present),
    .frame_tick(frame_tick), .held(held), .press(press),
    .release_pulse(release_pulse), .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_held = '0; m_cand = '0; e_press = '0; e_rel = '0; e_evt = '0;
  endtask

  task automatic model_step(input logic [NB-1:0] raw, input logic present);
    int d;
    tick_no++;
    e_press = '0; e_rel = '0; e_evt = '0;
    if (!present) begin
      e_rel  = m_held;
      m_held = '0;
      m_cand = '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (raw[i] != m_held[i] && m_cand[i]) begin
          m_cand[i] = 1'b0;
          m_held[i] = raw[i];
          if (raw[i]) begin
            e_press[i] = 1'b1; e_evt[i] = 1'b1; press_tick[i] = tick_no;
          end else begin
            e_rel[i] = 1'b1;
          end
        end else begin
          m_cand[i] = (raw[i] != m_held[i]);
          if (m_held[i]) begin
            d = tick_no - press_tick[i];
            if (d >= D && ((d - D) % R) == 0) e_evt[i] = 1'b1;
          end
        end
      end
    end
  endtask

  // Drives one tick; returns on the negedge after the sampling edge.
  task automatic do_tick(input logic [NB-1:0] raw, input logic present);
    @(negedge clk);
    btn_raw = raw; is_present = present; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_step(raw, present);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(3);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if ({held, press, release_pulse, evt} !== '0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", {held, press, release_pulse, evt});
    end
    do_tick(12'hFFF, 1'b1);
    do_tick(12'hFFF, 1'b1);
    checks++;
    if (held !== 12'hFFF || press !== 12'hFFF) begin
      errors++; $display("FAIL reset_preload: held=%h press=%h expected FFF FFF", held, press);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({held, press, release_pulse, evt} !== '0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", {held, press, release_pulse, evt});
    end
    frame_tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({held, press, release_pulse, evt} !== '0) begin
        errors++; $display("FAIL reset_hold: cycle %0d got %h expected 0", c, {held, press, release_pulse, evt});
      end
    end
    frame_tick = 1'b0;
    btn_raw = '0;
    rst_n = 1'b1;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      do_tick('0, 1'b1);
      checks++;
      if ({held, press, release_pulse, evt} !== '0) begin
        errors++; $display("FAIL reset_exit: tick %0d got %h expected 0", t, {held, press, release_pulse, evt});
      end
    end
  endtask

  task automatic test_press_hold();
    logic [NB-1:0] raw;
    raw = 12'h080;
    for (int t = 1; t <= 12; t++) begin
      do_tick(raw, 1'b1);
      checks++;
      if (held !== m_held || press !== e_press || release_pulse !== e_rel || evt !== e_evt) begin
        errors++;
        $display("FAIL press_hold t%0d: got h=%h p=%h r=%h e=%h expected h=%h p=%h r=%h e=%h",
                 t, held, press, release_pulse, evt, m_held, e_press, e_rel, e_evt);
      end
      checks++;
      if (evt[7] !== (t == 2 || t == 5 || t == 7 || t == 9 || t == 11)) begin
        errors++; $display("FAIL press_hold_sched t%0d: evt7=%b", t, evt[7]);
      end
      idle(1);
      checks++;
      if ({press, release_pulse, evt} !== '0 || held !== m_held) begin
        errors++; $display("FAIL press_hold_pulse_width t%0d: p=%h r=%h e=%h held=%h", t, press, release_pulse, evt, held);
      end
      idle(14);
    end
    do_tick('0, 1'b1);
    do_tick('0, 1'b1);
    checks++;
    if (held !== '0 || release_pulse !== 12'h080) begin
      errors++; $display("FAIL press_hold_release: held=%h rel=%h expected 000 080", held, release_pulse);
    end
  endtask

  task automatic test_glitch();
    logic [NB-1:0] seq [4];
    seq[0] = 12'h040; seq[1] = 12'h000; seq[2] = 12'h040; seq[3] = 12'h000;
    for (int t = 0; t < 4; t++) begin
      do_tick(seq[t], 1'b1);
      checks++;
      if ({held, press, release_pulse, evt} !== '0) begin
        errors++; $display("FAIL glitch t%0d: got %h expected 0", t, {held, press, release_pulse, evt});
      end
    end
  endtask

  task automatic test_release_collision();
    for (int t = 1; t <= 10; t++) begin
      do_tick((t >= 6) ? 12'h000 : 12'h080, 1'b1);
      checks++;
      if (held !== m_held || press !== e_press || release_pulse !== e_rel || evt !== e_evt) begin
        errors++;
        $display("FAIL collision t%0d: got h=%h p=%h r=%h e=%h expected h=%h p=%h r=%h e=%h",
                 t, held, press, release_pulse, evt, m_held, e_press, e_rel, e_evt);
      end
      if (t == 7) begin
        checks++;
        if (release_pulse !== 12'h080 || evt !== '0 || held !== '0) begin
          errors++; $display("FAIL collision_tick7: rel=%h evt=%h held=%h expected 080 000 000", release_pulse, evt, held);
        end
      end
      idle(2);
    end
  endtask

  task automatic test_unplug();
    for (int t = 0; t < 7; t++) do_tick(12'h880, 1'b1);
    do_tick(12'h880, 1'b0);
    checks++;
    if (held !== '0 || release_pulse !== 12'h880 || evt !== '0 || press !== '0) begin
      errors++; $display("FAIL unplug: held=%h rel=%h evt=%h press=%h expected 000 880 000 000", held, release_pulse, evt, press);
    end
    for (int t = 0; t < 6; t++) begin
      do_tick(12'($urandom), 1'b0);
      checks++;
      if ({held, press, release_pulse, evt} !== '0) begin
        errors++; $display("FAIL unplug_ignore t%0d: got %h expected 0", t, {held, press, release_pulse, evt});
      end
    end
    do_tick('0, 1'b1);
    do_tick('0, 1'b1);
    checks++;
    if ({held, press, release_pulse, evt} !== '0) begin
      errors++; $display("FAIL unplug_replug: got %h expected 0", {held, press, release_pulse, evt});
    end
  endtask

  task automatic test_no_tick();
    logic [NB-1:0] h0;
    int bad;
    h0 = held;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      btn_raw = 12'($urandom);
      is_present = $urandom_range(0, 1) == 1;
      if (held !== h0 || {press, release_pulse, evt} !== '0) bad++;
    end
    is_present = 1'b1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_tick: %0d cycles changed, expected 0", bad);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] raw;
    logic          pres;
    int            gap;
    raw = btn_raw;
    for (int t = 0; t < 300; t++) begin
      raw  = raw ^ (12'($urandom) & 12'($urandom) & 12'($urandom));
      pres = ($urandom_range(0, 24) != 0);
      do_tick(raw, pres);
      checks++;
      if (held !== m_held || press !== e_press || release_pulse !== e_rel || evt !== e_evt) begin
        errors++;
        $display("FAIL random t%0d: got h=%h p=%h r=%h e=%h expected h=%h p=%h r=%h e=%h",
                 t, held, press, release_pulse, evt, m_held, e_press, e_rel, e_evt);
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idle(gap);
        checks++;
        if ({press, release_pulse, evt} !== '0 || held !== m_held) begin
          errors++; $display("FAIL random_gap t%0d: p=%h r=%h e=%h held=%h expected 0 0 0 %h",
                             t, press, release_pulse, evt, held, m_held);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Ticks on consecutive cycles with several buttons committing together.
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      btn_raw = (t < 8) ? 12'h0C3 : 12'h000; is_present = 1'b1; frame_tick = 1'b1;
      @(posedge clk);
      #1;
      model_step(btn_raw, 1'b1);
      checks++;
      if (held !== m_held || press !== e_press || release_pulse !== e_rel || evt !== e_evt) begin
        errors++;
        $display("FAIL back_to_back t%0d: got h=%h p=%h r=%h e=%h expected h=%h p=%h r=%h e=%h",
                 t, held, press, release_pulse, evt, m_held, e_press, e_rel, e_evt);
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) press_tick[i] = 0;
    test_reset();
    test_press_hold();
    test_glitch();
    test_release_collision();
    test_unplug();
    test_no_tick();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
